// File: rtl/iir_channel_scheduler_if.sv
// Handshake bundle between the per-channel sample sources, the shared IIR
// scheduler and the downstream consumer of tagged results.
interface iir_channel_scheduler_if #(
  parameter int N   = 15,
  parameter int CH  = 4,
  parameter int CHW = 2
);
  logic [CH-1:0]   in_valid;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic [CH-1:0]   clr;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [CHW-1:0]  out_ch;
  logic            out_ready;
  logic            busy;

  modport slave (
    input  in_valid, in_data, clr, out_ready,
    output in_ready, out_valid, out_data, out_ch, busy
  );

  modport master (
    output in_valid, in_data, clr, out_ready,
    input  in_ready, out_valid, out_data, out_ch, busy
  );
endinterface

// File: rtl/iir_channel_scheduler.sv
// Round-robin time-multiplexed first-order IIR (y = x + s/2 + s/4) over CH channels.
// Define IIR_SATURATE_EN to clamp the result instead of wrapping it.
module iir_channel_scheduler #(
  parameter int N   = 15,
  parameter int CH  = 4,
  parameter int CHW = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  iir_channel_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

  state_t                state_q, state_d;
  logic [CHW-1:0]        rr_ptr_q;
  logic signed [N-1:0]   x_q;
  logic [CHW-1:0]        ch_q;
  logic signed [N-1:0]   st_q [CH];
  logic                  out_valid_q;
  logic [N-1:0]          out_data_q;
  logic [CHW-1:0]        out_ch_q;

  logic [N-1:0]          in_slice [CH];
  logic                  grant_found;
  logic [CHW-1:0]        grant_idx;
  logic [CHW:0]          scan_idx;
  logic                  accept;
  logic signed [N-1:0]   s_cur;
  logic signed [N+1:0]   s_ext, x_ext, sum;
  logic signed [N-1:0]   y;

  for (genvar gi = 0; gi < CH; gi++) begin : g_slice
    assign in_slice[gi] = bus.in_data[gi*N +: N];
  end

  // Scan from the highest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (CHW+1)'(k);
      if (scan_idx >= (CHW+1)'(CH)) scan_idx = scan_idx - (CHW+1)'(CH);
      if (bus.in_valid[scan_idx[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CHW-1:0];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found && !reset;

  always_comb begin
    bus.in_ready = '0;
    if (accept) bus.in_ready[grant_idx] = 1'b1;
  end

  assign s_cur = st_q[ch_q];
  assign s_ext = {{2{s_cur[N-1]}}, s_cur};
  assign x_ext = {{2{x_q[N-1]}}, x_q};
  assign sum   = x_ext + (s_ext >>> 1) + (s_ext >>> 2);

`ifdef IIR_SATURATE_EN
  always_comb begin
    if (sum > SAT_MAX)      y = SAT_MAX[N-1:0];
    else if (sum < SAT_MIN) y = SAT_MIN[N-1:0];
    else                    y = sum[N-1:0];
  end
`else
  assign y = sum[N-1:0];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      x_q         <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q      <= in_slice[grant_idx];
        ch_q     <= grant_idx;
        rr_ptr_q <= (grant_idx == CHW'(CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state_q == CALC) begin
        out_valid_q <= 1'b1;
        out_data_q  <= y;
        out_ch_q    <= ch_q;
      end else if (state_q == OUT && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // A clear landing on the same edge as the CALC write-back takes priority.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (reset || bus.clr[i])                         st_q[i] <= '0;
      else if (state_q == CALC && ch_q == CHW'(i))     st_q[i] <= y;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
